// File: rtl/data_mem_responder.sv
// data_mem_responder
// Word-organised data memory that answers the MEM-stage load/store port.
// Each request is accepted over valid/ready. The responder then spends
// WAIT_CYCLES cycles waiting and produces a single-cycle response carrying
// the load data, or zero for a store, plus an error flag.
// Only one request is outstanding at a time. Requests are never overlapped.
// Optional feature, macro DMEM_CLEAR_ON_RESET_EN: reset first walks a CLEAR
// state that zeroes every word. Without the macro the memory keeps its
// contents across reset.
module data_mem_responder #(
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 2,
   parameter int ADDR_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

`ifdef DMEM_CLEAR_ON_RESET_EN
   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP, ST_CLEAR} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
`endif

   state_t            state;
   state_t            state_next;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_next;
   logic              enter_resp;

   logic              cap_write;
   logic [ADDR_W-1:0] cap_addr;
   logic [31:0]       cap_wdata;

   logic              cur_write;
   logic [ADDR_W-1:0] cur_addr;
   logic [31:0]       cur_wdata;
   logic [IDX_W-1:0]  cur_idx;
   logic              cur_oor;
   logic              cur_err;
   logic              accept;
   logic              commit;

   logic [31:0]       rdata_q;
   logic              err_q;
   logic [31:0]       mem [DEPTH];

`ifdef DMEM_CLEAR_ON_RESET_EN
   logic [IDX_W-1:0]  clr_idx;
`endif

   // While idle the live request is the one on the port. This lets a
   // zero-wait request commit on its own acceptance edge. Afterwards the
   // captured copy is used.
   assign cur_write = (state == ST_IDLE) ? req_write : cap_write;
   assign cur_addr  = (state == ST_IDLE) ? req_addr  : cap_addr;
   assign cur_wdata = (state == ST_IDLE) ? req_wdata : cap_wdata;
   assign cur_idx   = cur_addr[IDX_W+1:2];

   generate
      if (ADDR_W > IDX_W + 2) begin : g_oor
         assign cur_oor = |cur_addr[ADDR_W-1:IDX_W+2];
      end else begin : g_no_oor
         assign cur_oor = 1'b0;
      end
   endgenerate

   assign cur_err = (cur_addr[1:0] != 2'b00) || cur_oor;
   assign accept  = (state == ST_IDLE) && req_valid;
   assign commit  = enter_resp && cur_write && !cur_err && !rst;

   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

   // Next-state, wait counter and handshake outputs
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      enter_resp = 1'b0;
      case (state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               cnt_next = CNT_LOAD;
               if (WAIT_CYCLES == 0) begin
                  state_next = ST_RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_next = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (cnt == '0) begin
               state_next = ST_RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_next = cnt - CNT_W'(1);
            end
         end
         ST_RESP: begin
            resp_valid = 1'b1;
            state_next = ST_IDLE;
         end
`ifdef DMEM_CLEAR_ON_RESET_EN
         ST_CLEAR: begin
            if (clr_idx == IDX_W'(DEPTH - 1)) begin
               state_next = ST_IDLE;
            end
         end
`endif
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // State and counter registers; reset abandons any request in flight
   always_ff @(posedge clk) begin
      if (rst) begin
`ifdef DMEM_CLEAR_ON_RESET_EN
         state   <= ST_CLEAR;
         clr_idx <= '0;
`else
         state   <= ST_IDLE;
`endif
         cnt     <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
`ifdef DMEM_CLEAR_ON_RESET_EN
         if (state == ST_CLEAR) begin
            clr_idx <= clr_idx + IDX_W'(1);
         end
`endif
      end
   end

   // Hold the accepted request so the initiator may change its inputs
   always_ff @(posedge clk) begin
      if (!rst && accept) begin
         cap_write <= req_write;
         cap_addr  <= req_addr;
         cap_wdata <= req_wdata;
      end
   end

   // Response data and error register; holds its value between responses
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else if (enter_resp) begin
         rdata_q <= (cur_write || cur_err) ? 32'd0 : mem[cur_idx];
         err_q   <= cur_err;
      end
   end

   // Memory array: stores commit on the edge entering RESP, or clearing sweeps
   always_ff @(posedge clk) begin
`ifdef DMEM_CLEAR_ON_RESET_EN
      if (state == ST_CLEAR) begin
         mem[clr_idx] <= '0;
      end else if (commit) begin
         mem[cur_idx] <= cur_wdata;
      end
`else
      if (commit) begin
         mem[cur_idx] <= cur_wdata;
      end
`endif
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
// Two responders share one clock and reset: index 0 uses WAIT_CYCLES=2 and
// index 1 uses WAIT_CYCLES=0. Requests are checked against a word-level
// memory model built from the addressing and latency rules.
// The bench honours DMEM_CLEAR_ON_RESET_EN when the design is built with it.
module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid  [2];
   logic        req_write  [2];
   logic [31:0] req_addr   [2];
   logic [31:0] req_wdata  [2];
   logic        req_ready  [2];
   logic        resp_valid [2];
   logic [31:0] resp_rdata [2];
   logic        resp_err   [2];

   int n_pass  = 0;
   int n_total = 0;
   logic [31:0] model_mem [int];

   // Free-running clock
   always #5 clk = ~clk;

   data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(2), .ADDR_W(32)) dut_w2 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
      .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
   );

   data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(0), .ADDR_W(32)) dut_w0 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
      .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
   );

   function automatic int wait_of(input int d);
      return (d == 0) ? 2 : 0;
   endfunction

   // Reference model: computes the expected response and applies any store
   task automatic model_apply(input int d, input bit wr, input logic [31:0] addr,
                              input logic [31:0] wd, output logic [31:0] exp_rd,
                              output bit exp_err, output bit known);
      int key;
      exp_err = (addr % 4 != 0) || (addr >= 32'd1024);
      key     = d * 4096 + int'(addr / 4);
      known   = 1'b1;
      exp_rd  = 32'd0;
      if (wr) begin
         if (!exp_err) model_mem[key] = wd;
      end else if (!exp_err) begin
         if (model_mem.exists(key)) exp_rd = model_mem[key];
`ifndef DMEM_CLEAR_ON_RESET_EN
         else known = 1'b0;
`endif
      end
   endtask

   // Issues one request and waits for its response; lat counts edges from acceptance
   task automatic do_txn(input int d, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd,
                         output logic er, output int lat);
      int guard = 0;
      while (req_ready[d] !== 1'b1 && guard < 600) begin
         @(posedge clk); #1; guard++;
      end
      req_valid[d] = 1'b1; req_write[d] = wr; req_addr[d] = addr; req_wdata[d] = wd;
      @(posedge clk); #1;
      req_valid[d] = 1'b0; req_write[d] = 1'($urandom);
      req_addr[d] = $urandom; req_wdata[d] = $urandom;
      lat = 1;
      while (resp_valid[d] !== 1'b1 && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
      rd = resp_rdata[d];
      er = resp_err[d];
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
`ifdef DMEM_CLEAR_ON_RESET_EN
      model_mem.delete();
`endif
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
`ifdef DMEM_CLEAR_ON_RESET_EN
         n_total++; if (req_ready[d] !== 1'b0) $display("[TB] FAIL reset_ready[%0d]: got %b expected 0", d, req_ready[d]); else n_pass++;
`else
         n_total++; if (req_ready[d] !== 1'b1) $display("[TB] FAIL reset_ready[%0d]: got %b expected 1", d, req_ready[d]); else n_pass++;
`endif
         n_total++; if (resp_valid[d] !== 1'b0) $display("[TB] FAIL reset_resp_valid[%0d]: got %b expected 0", d, resp_valid[d]); else n_pass++;
         n_total++; if (resp_rdata[d] !== 32'd0) $display("[TB] FAIL reset_rdata[%0d]: got %h expected 0", d, resp_rdata[d]); else n_pass++;
         n_total++; if (resp_err[d] !== 1'b0) $display("[TB] FAIL reset_err[%0d]: got %b expected 0", d, resp_err[d]); else n_pass++;
      end
      rst = 1'b0;
`ifdef DMEM_CLEAR_ON_RESET_EN
      model_mem.delete();
`endif
   endtask

   task automatic test_store_load();
      bit          wr_t [2] = '{1'b1, 1'b0};
      logic [31:0] rd, exp_rd;
      logic        er;
      bit          exp_err, known;
      int          lat;
      for (int i = 0; i < 2; i++) begin
         model_apply(0, wr_t[i], 32'h10, 32'hDEADBEEF, exp_rd, exp_err, known);
         do_txn(0, wr_t[i], 32'h10, 32'hDEADBEEF, rd, er, lat);
         n_total++; if (lat != 3) $display("[TB] FAIL store_load_latency[%0d]: got %0d expected 3", i, lat); else n_pass++;
         n_total++; if (er !== exp_err) $display("[TB] FAIL store_load_err[%0d]: got %b expected %b", i, er, exp_err); else n_pass++;
         n_total++; if (rd !== exp_rd) $display("[TB] FAIL store_load_rdata[%0d]: got %h expected %h", i, rd, exp_rd); else n_pass++;
         @(posedge clk); #1;
         n_total++; if (resp_valid[0] !== 1'b0) $display("[TB] FAIL store_load_pulse[%0d]: got %b expected 0", i, resp_valid[0]); else n_pass++;
         n_total++; if (resp_rdata[0] !== exp_rd) $display("[TB] FAIL store_load_hold[%0d]: got %h expected %h", i, resp_rdata[0], exp_rd); else n_pass++;
      end
   endtask

   task automatic test_errors();
      bit          wr_t [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [31:0] ad_t [5] = '{32'h0, 32'h13, 32'h400, 32'h400, 32'h0};
      logic [31:0] wd_t [5];
      logic [31:0] rd, exp_rd;
      logic        er;
      bit          exp_err, known;
      int          lat;
      wd_t = '{$urandom, 32'h0, 32'h0, 32'hCAFEF00D, 32'h0};
      for (int i = 0; i < 5; i++) begin
         model_apply(0, wr_t[i], ad_t[i], wd_t[i], exp_rd, exp_err, known);
         do_txn(0, wr_t[i], ad_t[i], wd_t[i], rd, er, lat);
         n_total++; if (lat != 3) $display("[TB] FAIL errors_latency[%0d]: got %0d expected 3", i, lat); else n_pass++;
         n_total++; if (er !== exp_err) $display("[TB] FAIL errors_err[%0d]: got %b expected %b", i, er, exp_err); else n_pass++;
         n_total++; if (rd !== exp_rd) $display("[TB] FAIL errors_rdata[%0d]: got %h expected %h", i, rd, exp_rd); else n_pass++;
         @(posedge clk); #1;
         n_total++; if (resp_err[0] !== exp_err) $display("[TB] FAIL errors_err_hold[%0d]: got %b expected %b", i, resp_err[0], exp_err); else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      int          n_req = 8;
      int          accepted = 0, responded = 0, cyc = 0, last_ready = -1;
      bit          adv;
      logic [31:0] exp_q [$];
      logic [31:0] exp_rd, got_exp;
      bit          exp_err, known;
      while (req_ready[0] !== 1'b1 && cyc < 600) begin
         @(posedge clk); #1; cyc++;
      end
      cyc = 0;
      req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h80; req_wdata[0] = $urandom;
      while ((accepted < n_req || responded < accepted) && cyc < 200) begin
         adv = 1'b0;
         if (resp_valid[0] === 1'b1) begin
            n_total++;
            if (exp_q.size() == 0) begin
               $display("[TB] FAIL b2b_extra_resp: got response at cycle %0d expected none", cyc);
            end else begin
               got_exp = exp_q.pop_front();
               responded++;
               if (resp_rdata[0] !== got_exp) $display("[TB] FAIL b2b_rdata[%0d]: got %h expected %h", responded, resp_rdata[0], got_exp);
               else n_pass++;
            end
         end
         if (req_ready[0] === 1'b1 && req_valid[0] === 1'b1) begin
            if (last_ready >= 0) begin
               n_total++;
               if (cyc - last_ready != 4) $display("[TB] FAIL b2b_ready_gap: got %0d expected 4", cyc - last_ready);
               else n_pass++;
            end
            last_ready = cyc;
            model_apply(0, req_write[0], req_addr[0], req_wdata[0], exp_rd, exp_err, known);
            exp_q.push_back(exp_rd);
            accepted++;
            adv = 1'b1;
         end
         @(posedge clk); #1; cyc++;
         if (adv) begin
            if (accepted < n_req) begin
               req_write[0] = ((accepted % 4) < 2);
               req_addr[0]  = 32'h80 + 32'(4 * (accepted % 2));
               req_wdata[0] = $urandom;
            end else begin
               req_valid[0] = 1'b0;
            end
         end
      end
      req_valid[0] = 1'b0;
      n_total++;
      if (accepted != n_req || responded != n_req)
         $display("[TB] FAIL b2b_count: got %0d accepted %0d responded expected %0d each", accepted, responded, n_req);
      else n_pass++;
   endtask

   task automatic test_wait0();
      bit          wr_t [2] = '{1'b1, 1'b0};
      logic [31:0] rd, exp_rd;
      logic        er;
      bit          exp_err, known;
      int          lat;
      for (int i = 0; i < 2; i++) begin
         model_apply(1, wr_t[i], 32'h0, 32'h1234, exp_rd, exp_err, known);
         do_txn(1, wr_t[i], 32'h0, 32'h1234, rd, er, lat);
         n_total++; if (lat != 1) $display("[TB] FAIL wait0_latency[%0d]: got %0d expected 1", i, lat); else n_pass++;
         n_total++; if (er !== exp_err) $display("[TB] FAIL wait0_err[%0d]: got %b expected %b", i, er, exp_err); else n_pass++;
         n_total++; if (rd !== exp_rd) $display("[TB] FAIL wait0_rdata[%0d]: got %h expected %h", i, rd, exp_rd); else n_pass++;
         @(posedge clk); #1;
         n_total++; if (resp_valid[1] !== 1'b0) $display("[TB] FAIL wait0_pulse[%0d]: got %b expected 0", i, resp_valid[1]); else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] prior = $urandom;
      logic [31:0] rd, exp_rd;
      logic        er;
      bit          exp_err, known;
      int          lat, guard = 0, stray = 0;
      model_apply(0, 1'b1, 32'h20, prior, exp_rd, exp_err, known);
      do_txn(0, 1'b1, 32'h20, prior, rd, er, lat);
      model_apply(0, 1'b0, 32'h20, 32'h0, exp_rd, exp_err, known);
      do_txn(0, 1'b0, 32'h20, 32'h0, rd, er, lat);
      while (req_ready[0] !== 1'b1 && guard < 600) begin
         @(posedge clk); #1; guard++;
      end
      req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h20; req_wdata[0] = 32'hAAAA5555;
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      pulse_reset();
`ifdef DMEM_CLEAR_ON_RESET_EN
      n_total++; if (req_ready[0] !== 1'b0) $display("[TB] FAIL mid_reset_ready: got %b expected 0", req_ready[0]); else n_pass++;
`else
      n_total++; if (req_ready[0] !== 1'b1) $display("[TB] FAIL mid_reset_ready: got %b expected 1", req_ready[0]); else n_pass++;
`endif
      n_total++; if (resp_rdata[0] !== 32'd0) $display("[TB] FAIL mid_reset_rdata: got %h expected 0", resp_rdata[0]); else n_pass++;
      n_total++; if (resp_err[0] !== 1'b0) $display("[TB] FAIL mid_reset_err: got %b expected 0", resp_err[0]); else n_pass++;
      for (int i = 0; i < 8; i++) begin
         if (resp_valid[0] === 1'b1) stray++;
         @(posedge clk); #1;
      end
      n_total++; if (stray != 0) $display("[TB] FAIL mid_reset_no_resp: got %0d pulses expected 0", stray); else n_pass++;
      model_apply(0, 1'b0, 32'h20, 32'h0, exp_rd, exp_err, known);
      do_txn(0, 1'b0, 32'h20, 32'h0, rd, er, lat);
      n_total++; if (rd !== exp_rd) $display("[TB] FAIL mid_reset_contents: got %h expected %h", rd, exp_rd); else n_pass++;
      n_total++; if (er !== 1'b0) $display("[TB] FAIL mid_reset_load_err: got %b expected 0", er); else n_pass++;
   endtask

   task automatic test_random();
      logic [31:0] rd, exp_rd, addr, wd;
      logic        er;
      bit          wr, exp_err, known;
      int          d, lat, idx;
      for (int i = 0; i < 24; i++) begin
         d   = int'($urandom_range(0, 1));
         wr  = 1'($urandom_range(0, 1));
         idx = ($urandom_range(0, 5) == 0) ? int'($urandom_range(250, 259)) : int'($urandom_range(0, 7));
         addr = 32'(idx * 4);
         if ($urandom_range(0, 6) == 0) addr = addr + 32'($urandom_range(1, 3));
         wd = $urandom;
         model_apply(d, wr, addr, wd, exp_rd, exp_err, known);
         do_txn(d, wr, addr, wd, rd, er, lat);
         n_total++; if (lat != wait_of(d) + 1) $display("[TB] FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, wait_of(d) + 1); else n_pass++;
         n_total++; if (er !== exp_err) $display("[TB] FAIL rand_err[%0d] addr %h: got %b expected %b", i, addr, er, exp_err); else n_pass++;
         if (known) begin
            n_total++; if (rd !== exp_rd) $display("[TB] FAIL rand_rdata[%0d] addr %h: got %h expected %h", i, addr, rd, exp_rd); else n_pass++;
         end
         @(posedge clk); #1;
      end
   endtask

`ifdef DMEM_CLEAR_ON_RESET_EN
   task automatic test_clear();
      logic [31:0] rd, exp_rd;
      logic        er;
      bit          exp_err, known;
      int          lat, low;
      model_apply(0, 1'b1, 32'h3FC, 32'hFFFFFFFF, exp_rd, exp_err, known);
      do_txn(0, 1'b1, 32'h3FC, 32'hFFFFFFFF, rd, er, lat);
      @(posedge clk); #1;
      pulse_reset();
      low = 0;
      while (req_ready[0] === 1'b0 && low < 600) begin
         @(posedge clk); #1; low++;
      end
      n_total++; if (low != 256) $display("[TB] FAIL clear_ready_low: got %0d expected 256", low); else n_pass++;
      model_apply(0, 1'b0, 32'h3FC, 32'h0, exp_rd, exp_err, known);
      do_txn(0, 1'b0, 32'h3FC, 32'h0, rd, er, lat);
      n_total++; if (rd !== exp_rd) $display("[TB] FAIL clear_contents: got %h expected %h", rd, exp_rd); else n_pass++;
      @(posedge clk); #1;
      pulse_reset();
      repeat (100) @(posedge clk);
      #1;
      pulse_reset();
      low = 0;
      while (req_ready[0] === 1'b0 && low < 600) begin
         @(posedge clk); #1; low++;
      end
      n_total++; if (low != 256) $display("[TB] FAIL clear_restart: got %0d expected 256", low); else n_pass++;
   endtask
`endif

   // Test sequence
   initial begin
      rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         req_valid[d] = 1'b0; req_write[d] = 1'b0; req_addr[d] = '0; req_wdata[d] = '0;
      end
      test_reset();
      test_store_load();
      test_errors();
      test_back_to_back();
      test_wait0();
      test_reset_mid();
      test_random();
`ifdef DMEM_CLEAR_ON_RESET_EN
      test_clear();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Word-organised data memory acting as the responder for the MEM-stage load/store interface.
- Accepts one request at a time over a valid/ready handshake.
- Inserts a programmable number of wait states, then returns read data or a write acknowledge with an error flag.
- Replaces the combinational data memory so the pipeline can be verified against realistic, non-zero memory latency.

Parameters:
- DEPTH, 256: number of 32-bit words; must be a power of two, at least 4.
- WAIT_CYCLES, 2: cycles spent in WAIT between acceptance and response; 0 is legal.
- ADDR_W, 32: width of the byte address.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  initiator presents a request
- req_ready  output  1  responder can accept a request this cycle
- req_write  input  1  1 = store, 0 = load
- req_addr  input  ADDR_W  byte address
- req_wdata  input  32  store data
- resp_valid  output  1  response present; single-cycle pulse
- resp_rdata  output  32  load data; 0 for stores and errors
- resp_err  output  1  request was misaligned or out of range

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0. Memory contents are unchanged (see Optional Feature).
- Handshake: a request is accepted on any edge where req_valid=1 and req_ready=1.
  - At acceptance, req_write, req_addr and req_wdata are captured into internal registers.
  - Inputs are don't-care after acceptance.
- req_ready=1 only in IDLE. This gives no pipelining and one outstanding request.
- FSM states:
  - IDLE: on acceptance go to WAIT, or directly to RESP if WAIT_CYCLES=0. Load counter with WAIT_CYCLES-1.
  - WAIT: decrement the counter each cycle; go to RESP when the counter reaches 0. Time spent in WAIT is exactly WAIT_CYCLES cycles.
  - RESP: resp_valid=1 for exactly one cycle, then return to IDLE. There is no resp_ready; the initiator must sample the response.
- Latency: the response is asserted WAIT_CYCLES+1 cycles after the acceptance edge. Back-to-back throughput is one request per WAIT_CYCLES+2 cycles.
- Address decode:
  - Word index = addr[log2(DEPTH)+1:2].
  - Error if addr[1:0] != 0 (misaligned), or if addr >= 4*DEPTH (out of range).
- Store:
  - The memory word is written on the edge that enters RESP, only if there is no error.
  - resp_rdata=0 during RESP.
  - An erroring store leaves memory untouched.
- Load:
  - resp_rdata = memory word at the captured index, read in the RESP cycle.
  - An erroring load returns 0 with resp_err=1.
- resp_rdata and resp_err hold their values outside RESP until the next RESP, except on reset, which clears both to 0.
- Ordering: a load issued after a store to the same address returns the stored data. This is guaranteed because requests are serialised.
- Reset mid-operation (in WAIT or RESP):
  - The request is abandoned; no response is issued.
  - A store not yet committed is discarded.
  - The FSM returns to IDLE the next cycle.
- req_valid asserted during WAIT or RESP is ignored; the initiator must hold it until req_ready=1.

Optional Feature:
- Macro: DMEM_CLEAR_ON_RESET_EN.
- Defined:
  - Adds a CLEAR state. Reset enters CLEAR with req_ready=0.
  - One word is zeroed per cycle, index 0 to DEPTH-1, over DEPTH cycles, then the FSM enters IDLE.
  - Reset during CLEAR restarts clearing from index 0.
  - req_valid during CLEAR is not accepted.
- Undefined:
  - No CLEAR state; reset goes straight to IDLE.
  - Memory contents persist across reset and are undefined at power-up.

Test Plan:
- WAIT_CYCLES=2, DEPTH=256:
  - Store 0xDEADBEEF to 0x10; resp_valid appears 3 cycles after acceptance with resp_err=0 and resp_rdata=0.
  - A following load from 0x10 returns 0xDEADBEEF 3 cycles after its acceptance.
- Load from 0x13 (misaligned) and from 0x400 (out of range): resp_err=1, resp_rdata=0. A store to 0x400 followed by a load from 0x0 shows word 0 is unchanged.
- Hold req_valid=1 continuously with alternating addresses: req_ready is high only one cycle in every 4. Exactly one resp_valid pulse per accepted request; no request is lost or duplicated.
- WAIT_CYCLES=0: store 0x1234 to 0x0, then load from 0x0; each response arrives 1 cycle after acceptance and the load returns 0x1234.
- Assert rst in the WAIT cycle of a store of 0xAAAA5555 to 0x20: no resp_valid follows, and a subsequent load from 0x20 returns the prior contents. After reset, req_ready=1, resp_rdata=0 and resp_err=0.
- With DMEM_CLEAR_ON_RESET_EN:
  - After writing 0xFFFFFFFF to 0x3FC, pulse rst; req_ready stays 0 for 256 cycles.
  - A following load from 0x3FC returns 0.
  - Re-asserting rst at clear index 100 restarts the 256-cycle count.
